lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator that drives the data port of the unified memory block (Op2En/Op2RW/R_W_Addr/DataWrite in, DataRead out) on behalf of the CPU datapath.
- Accepts one byte/half/word request at a time, issues word accesses, and performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data and flags misaligned requests without touching memory.

Parameters:
- MEM_LATENCY, 1, cycles from the Op2En read cycle until DataRead is valid; must be >= 1.
- ADDR_W, 32, request and memory address width.

Ports:
- clk  in  1  clock, rising edge
- Clear  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and accepting
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal (treated as misaligned)
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  misaligned/illegal, qualified by resp_valid
- resp_rdata  out  32  load result, qualified by resp_valid; 0 for stores/errors
- R_W_Addr  out  ADDR_W  word-aligned memory address, {req_addr[ADDR_W-1:2],2'b00}
- DataWrite  out  32  memory write data
- Op2En  out  1  memory data-port enable
- Op2RW  out  1  1=write, 0=read
- DataRead  in  32  memory read data

Behaviour:
- All outputs are registered. On Clear: state=IDLE, req_ready=1, all other outputs 0, and the wait counter is 0.
- Little-endian: byte lane = addr[1:0]; half lane = addr[1].
- Handshake: a request is accepted on a rising edge where req_valid & req_ready. req_ready=1 only in IDLE. The request fields are latched at acceptance; later changes are ignored.
- States:
  - IDLE: on accept:
    - misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=3) -> ERR;
    - word store -> WR;
    - otherwise -> RD.
  - RD: Op2En=1, Op2RW=0, for exactly 1 cycle -> WAIT with counter=MEM_LATENCY.
  - WAIT: Op2En=0. Decrement the counter. When it reaches 0, sample DataRead at that edge.
    - Load -> RESP with extracted/extended data.
    - Sub-word store -> MERGE.
  - MERGE: replace the selected byte/half lane of the sampled word with req_wdata[7:0]/[15:0] -> WR. Takes 1 cycle; memory is idle.
  - WR: Op2En=1, Op2RW=1, DataWrite=merged word or req_wdata, for exactly 1 cycle -> RESP.
  - RESP: resp_valid=1, resp_err=0 -> IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0, no memory enable -> IDLE.
- Latency, with acceptance in cycle 0:
  - misaligned: resp in cycle 1;
  - word store: WR cycle 1, resp cycle 2;
  - load: RD cycle 1, resp cycle 2+MEM_LATENCY;
  - sub-word store: resp cycle 4+MEM_LATENCY.
- Load extension: byte/half sign-extended if req_signed, else zero-extended. A word load is passed through unchanged.
- No backpressure on the response. The next request can be accepted in the cycle after resp_valid.
- R_W_Addr holds the latched word address from acceptance until return to IDLE, then returns to 0.
- DataWrite is 0 except in WR.
- Clear mid-operation: Op2En drops immediately (async), no response is produced, and a pending RMW write is never issued.

Optional Feature:
- Macro LSU_STATS_EN.
- Defined: adds output ports ld_cnt[15:0], st_cnt[15:0], err_cnt[15:0], zeroed by Clear. Each increments once per completed response of its kind and saturates at 16'hFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: Clear=1 for 2 cycles -> req_ready=1, Op2En=0, resp_valid=0, R_W_Addr=0. Release and keep idle 5 cycles -> no memory enable.
- Word store/load, MEM_LATENCY=1:
  - store addr=0x10, data=0xDEADBEEF -> Op2En=1, Op2RW=1, R_W_Addr=0x10, DataWrite=0xDEADBEEF in cycle 1, resp_valid in cycle 2.
  - word load 0x10 -> resp_rdata=0xDEADBEEF in cycle 3.
- Signed byte load from memory word 0x80FF7F01, addr=0x13:
  - req_signed=1 -> resp_rdata=0xFFFFFF80;
  - req_signed=0 -> 0x00000080.
  - addr=0x12, half, signed -> 0xFFFF80FF.
- Sub-word store RMW with word 0x11223344 at 0x20: byte store addr=0x21, data=0xAA -> read cycle, then a write of DataWrite=0x1122AA44, resp_valid in cycle 5.
- Misaligned: half at 0x21, word at 0x22, size=3 at 0x20 -> each gives resp_valid=1, resp_err=1 in cycle 1, with Op2En never asserted.
- Clear asserted during WAIT of a byte store -> Op2En=0 immediately, no write or resp follows, memory word unchanged, and the next request is accepted normally.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for the data port of the unified memory.
// Takes one byte/half/word request at a time, issues word-wide memory accesses,
// performs read-modify-write for sub-word stores and returns sign/zero-extended
// load data. Misaligned or illegal-size requests are answered with resp_err
// without touching memory.
//
// Ports:
//   clk, Clear        clock (rising edge), asynchronous active-high reset
//   req_*             request channel; accepted when req_valid & req_ready
//   resp_*            one-cycle completion pulse with error flag and load data
//   R_W_Addr, DataWrite, Op2En, Op2RW, DataRead   memory data port
//   ld_cnt, st_cnt, err_cnt   saturating completion counters (LSU_STATS_EN only)
//
// Optional feature macro: LSU_STATS_EN.
module lsu_mem_master #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              Clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] R_W_Addr,
  output logic [31:0]       DataWrite,
  output logic              Op2En,
  output logic              Op2RW,
  input  logic [31:0]       DataRead
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]       ld_cnt,
  output logic [15:0]       st_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, RD, WAIT, MERGE, WR, RESP, ERR} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                rvalid_q, rvalid_d;
  logic                rerr_q, rerr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         dwrite_q, dwrite_d;
  logic                en_q, en_d;
  logic                rw_q, rw_d;

  // Request fields latched at acceptance, plus the word sampled for RMW.
  logic                wr_q;
  logic [1:0]          size_q;
  logic                sgn_q;
  logic [1:0]          lane_q;
  logic [31:0]         wdata_q;
  logic [31:0]         word_q;

  logic                accept;
  logic                last_wait;

  assign accept    = req_valid & ready_q;
  assign last_wait = (state_q == WAIT) && (cnt_q == CNT_W'(1));

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] lane, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    extract = {{24{sg & b[7]}}, b};
      2'd1:    extract = {{16{sg & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] m;
    m = w;
    if (sz == 2'd0) begin
      m[{lane, 3'b000} +: 8] = d[7:0];
    end else if (lane[1]) begin
      m[31:16] = d[15:0];
    end else begin
      m[15:0] = d[15:0];
    end
    merge = m;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned(req_size, req_addr[1:0]))   state_d = ERR;
          else if (req_write && req_size == 2'd2)   state_d = WR;
          else                                      state_d = RD;
        end
      end
      RD: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(MEM_LATENCY);
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (last_wait) begin
          if (wr_q) begin
            state_d = MERGE;
          end else begin
            state_d = RESP;
            rdata_d = extract(DataRead, size_q, lane_q, sgn_q);
          end
        end
      end
      MERGE:   state_d = WR;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every output is registered, so it is derived from the state being entered.
    ready_d  = (state_d == IDLE);
    en_d     = (state_d == RD) || (state_d == WR);
    rw_d     = (state_d == WR);
    rvalid_d = (state_d == RESP) || (state_d == ERR);
    rerr_d   = (state_d == ERR);

    if (state_d == IDLE)  addr_d = '0;
    else if (accept)      addr_d = {req_addr[ADDR_W-1:2], 2'b00};
    else                  addr_d = addr_q;

    // A WR entered from MERGE writes the merged word; from IDLE it is a word store.
    if (state_d != WR)          dwrite_d = '0;
    else if (state_q == MERGE)  dwrite_d = merge(word_q, wdata_q, size_q, lane_q);
    else                        dwrite_d = req_wdata;
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dwrite_q <= '0;
      en_q     <= 1'b0;
      rw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      dwrite_q <= dwrite_d;
      en_q     <= en_d;
      rw_q     <= rw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      size_q  <= req_size;
      sgn_q   <= req_signed;
      lane_q  <= req_addr[1:0];
      wdata_q <= req_wdata;
    end
    if (last_wait) begin
      word_q <= DataRead;
    end
  end

`ifdef LSU_STATS_EN
  logic [15:0] ld_q, st_q, err_q;

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      ld_q  <= '0;
      st_q  <= '0;
      err_q <= '0;
    end else begin
      if (state_q == RESP && !wr_q && ld_q != 16'hFFFF)  ld_q  <= ld_q + 16'd1;
      if (state_q == RESP && wr_q && st_q != 16'hFFFF)   st_q  <= st_q + 16'd1;
      if (state_q == ERR && err_q != 16'hFFFF)           err_q <= err_q + 16'd1;
    end
  end

  assign ld_cnt  = ld_q;
  assign st_cnt  = st_q;
  assign err_cnt = err_q;
`endif

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_err   = rerr_q;
  assign resp_rdata = rdata_q;
  assign R_W_Addr   = addr_q;
  assign DataWrite  = dwrite_q;
  assign Op2En      = en_q;
  assign Op2RW      = rw_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

  logic        clk;
  logic        Clear;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] R_W_Addr;
  logic [31:0] DataWrite;
  logic        Op2En;
  logic        Op2RW;
  logic [31:0] DataRead;
`ifdef LSU_STATS_EN
  logic [15:0] ld_cnt, st_cnt, err_cnt;
`endif

  lsu_mem_master #(.MEM_LATENCY(1), .ADDR_W(32)) dut (
    .clk        (clk),
    .Clear      (Clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .R_W_Addr   (R_W_Addr),
    .DataWrite  (DataWrite),
    .Op2En      (Op2En),
    .Op2RW      (Op2RW),
    .DataRead   (DataRead)
`ifdef LSU_STATS_EN
    ,
    .ld_cnt     (ld_cnt),
    .st_cnt     (st_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 64 words, one-cycle read latency.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (Op2En) begin
      if (Op2RW) mem[R_W_Addr[7:2]] = DataWrite;
      else       DataRead <= mem[R_W_Addr[7:2]];
    end
  end

  int en_cnt = 0;
  int wr_cnt = 0;
  int resp_cnt = 0;
  always @(posedge clk) begin
    if (Op2En)          en_cnt++;
    if (Op2En && Op2RW) wr_cnt++;
    if (resp_valid)     resp_cnt++;
  end

  int total = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
  // Request inputs are scrambled after acceptance to show they were latched.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = ~w;
    req_size   = 2'd2;
    req_signed = ~sg;
    req_addr   = 32'hFFFF_FFFC;
    req_wdata  = 32'h0;
    @(negedge clk);
  endtask

  task automatic load_check(input string tag, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, sz, sg, a, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, resp_valid, 1'b1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    @(negedge clk);
  endtask

  task automatic store_sub(input string tag, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_word);
    issue(1'b1, sz, 1'b0, a, d);
    chk({tag, "_rd_en"}, Op2En, 1'b1);
    chk({tag, "_rd_rw"}, Op2RW, 1'b0);
    chk({tag, "_rd_addr"}, R_W_Addr, {a[31:2], 2'b00});
    @(negedge clk);
    chk({tag, "_wait_en"}, Op2En, 1'b0);
    @(negedge clk);
    chk({tag, "_merge_en"}, Op2En, 1'b0);
    @(negedge clk);
    chk({tag, "_wr_en"}, Op2En, 1'b1);
    chk({tag, "_wr_rw"}, Op2RW, 1'b1);
    chk({tag, "_wr_data"}, DataWrite, exp_word);
    chk({tag, "_wr_resp"}, resp_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_resp"}, resp_valid, 1'b1);
    chk({tag, "_err"}, resp_err, 1'b0);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_mem"}, mem[a[7:2]], exp_word);
    @(negedge clk);
  endtask

  task automatic mis(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a);
    int e0;
    e0 = en_cnt;
    issue(w, sz, 1'b1, a, 32'hFFFF_FFFF);
    chk({tag, "_valid"}, resp_valid, 1'b1);
    chk({tag, "_err"}, resp_err, 1'b1);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, 1'b1);
    chk({tag, "_no_en"}, en_cnt, e0);
  endtask

  initial begin
    int r0, w0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    DataRead   = 32'h0;
    Clear      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_en", Op2En, 1'b0);
    chk("rst_resp", resp_valid, 1'b0);
    chk("rst_addr", R_W_Addr, 32'h0);
    chk("rst_dw", DataWrite, 32'h0);
    Clear = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_no_en", en_cnt, 0);

    // Word store
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("ws_en", Op2En, 1'b1);
    chk("ws_rw", Op2RW, 1'b1);
    chk("ws_addr", R_W_Addr, 32'h10);
    chk("ws_dw", DataWrite, 32'hDEADBEEF);
    chk("ws_ready", req_ready, 1'b0);
    chk("ws_noresp", resp_valid, 1'b0);
    @(negedge clk);
    chk("ws_resp", resp_valid, 1'b1);
    chk("ws_err", resp_err, 1'b0);
    chk("ws_rdata", resp_rdata, 32'h0);
    chk("ws_en2", Op2En, 1'b0);
    chk("ws_dw0", DataWrite, 32'h0);
    @(negedge clk);
    chk("ws_idle", req_ready, 1'b1);
    chk("ws_addr0", R_W_Addr, 32'h0);
    chk("ws_mem", mem[4], 32'hDEADBEEF);

    // Word load
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("wl_en", Op2En, 1'b1);
    chk("wl_rw", Op2RW, 1'b0);
    chk("wl_addr", R_W_Addr, 32'h10);
    @(negedge clk);
    chk("wl_wait_en", Op2En, 1'b0);
    chk("wl_wait_resp", resp_valid, 1'b0);
    @(negedge clk);
    chk("wl_resp", resp_valid, 1'b1);
    chk("wl_rdata", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Sub-word loads
    mem[4] = 32'h80FF7F01;
    load_check("lb_s3", 2'd0, 1'b1, 32'h13, 32'hFFFFFF80);
    load_check("lb_u3", 2'd0, 1'b0, 32'h13, 32'h00000080);
    load_check("lh_s2", 2'd1, 1'b1, 32'h12, 32'hFFFF80FF);
    load_check("lh_u2", 2'd1, 1'b0, 32'h12, 32'h000080FF);
    load_check("lb_s0", 2'd0, 1'b1, 32'h10, 32'h00000001);
    load_check("lb_s1", 2'd0, 1'b1, 32'h11, 32'h0000007F);
    load_check("lh_s0", 2'd1, 1'b1, 32'h10, 32'h00007F01);
    load_check("lw_s",  2'd2, 1'b1, 32'h10, 32'h80FF7F01);

    // Read-modify-write stores
    mem[8] = 32'h11223344;
    store_sub("sb21", 2'd0, 32'h21, 32'h123456AA, 32'h1122AA44);
    store_sub("sh22", 2'd1, 32'h22, 32'h0000BEEF, 32'hBEEFAA44);

    // Misaligned / illegal
    mis("mis_h21", 1'b0, 2'd1, 32'h21);
    mis("mis_w22", 1'b1, 2'd2, 32'h22);
    mis("mis_s3",  1'b0, 2'd3, 32'h20);

    // Clear during WAIT of a byte store
    mem[12] = 32'hCAFEF00D;
    r0 = resp_cnt;
    w0 = wr_cnt;
    issue(1'b1, 2'd0, 1'b0, 32'h31, 32'h00000055);
    chk("clr_rd_en", Op2En, 1'b1);
    @(negedge clk);
    Clear = 1'b1;
    #1;
    chk("clr_ready", req_ready, 1'b1);
    chk("clr_en", Op2En, 1'b0);
    chk("clr_addr", R_W_Addr, 32'h0);
    @(negedge clk);
    Clear = 1'b0;
    repeat (6) @(negedge clk);
    chk("clr_no_resp", resp_cnt, r0);
    chk("clr_no_wr", wr_cnt, w0);
    chk("clr_mem", mem[12], 32'hCAFEF00D);
    load_check("clr_ld", 2'd2, 1'b0, 32'h30, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
